// File: rtl/instr_encoder.sv
// instr_encoder: packs MIPS R/I/J field bundles into 32-bit words and writes
// them to instruction memory at an auto-incrementing word address.
// Latency: one cycle from accept to mem_we; one word per cycle sustained.
// Backpressure: in_ready drops while a presented word waits on mem_ready.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   start                      opens a new program at address 0 (any state)
//   in_valid/in_ready          field bundle handshake
//   fmt, opcode, rs, rt, rd, shamt, funct, imm, addr   instruction fields
//   mem_we/mem_ready           write handshake; mem_addr/mem_wdata held stable
//   word_count                 words written since the last start
//   full                       memory filled; only start/reset leaves
//   err                        one-cycle pulse when a bundle is dropped
//
// Optional feature: define ENCODER_FIELD_CHECK_EN to reject bundles whose
// opcode does not match the selected format.

module instr_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [5:0]        opcode,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       addr,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              full,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    localparam logic [1:0]        FMT_R    = 2'b00;
    localparam logic [1:0]        FMT_I    = 2'b01;
    localparam logic [1:0]        FMT_J    = 2'b10;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;

    state_t      state;
    state_t      next_state;

    logic        done;
    logic        last_addr;
    logic        last_done;
    logic        accept;
    logic        fmt_ok;
    logic        write_new;
    logic        drop;
    logic [31:0] packed_word;

    assign done      = mem_we && mem_ready;
    assign last_addr = (mem_addr == {ADDR_W{1'b1}});
    assign last_done = done && last_addr;
    assign in_ready  = (state == ST_RUN) && (!mem_we || mem_ready);
    // start wins over a same-cycle bundle: the bundle is left unconsumed.
    assign accept    = in_valid && in_ready && !start;
    // A bundle arriving as the final slot is written has nowhere to go.
    assign write_new = accept && fmt_ok && !last_done;
    assign drop      = accept && !write_new;

    always_comb begin
        packed_word = 32'd0;
        case (fmt)
            FMT_R:   packed_word = {opcode, rs, rt, rd, shamt, funct};
            FMT_I:   packed_word = {opcode, rs, rt, imm};
            FMT_J:   packed_word = {opcode, addr};
            default: packed_word = 32'd0;
        endcase
    end

    always_comb begin
        fmt_ok = 1'b0;
`ifdef ENCODER_FIELD_CHECK_EN
        case (fmt)
            FMT_R:   fmt_ok = (opcode == 6'd0);
            FMT_I:   fmt_ok = (opcode != 6'd0) && (opcode != 6'd2) && (opcode != 6'd3);
            FMT_J:   fmt_ok = (opcode == 6'd2) || (opcode == 6'd3);
            default: fmt_ok = 1'b0;
        endcase
`else
        fmt_ok = (fmt != 2'b11);
`endif
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM: next state
    always_comb begin
        next_state = state;
        if (start) begin
            next_state = ST_RUN;
        end else if ((state == ST_RUN) && last_done) begin
            next_state = ST_FULL;
        end
    end

    // Datapath: output register, address and count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
            word_count <= '0;
            full       <= 1'b0;
            err        <= 1'b0;
        end else if (start) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            word_count <= '0;
            full       <= 1'b0;
            err        <= 1'b0;
        end else begin
            err <= drop;
            if (done) begin
                // The address wraps to 0 naturally after the last slot.
                mem_addr   <= mem_addr + ADDR_ONE;
                word_count <= word_count + CNT_ONE;
                if (last_addr) begin
                    full <= 1'b1;
                end
            end
            if (write_new) begin
                mem_we    <= 1'b1;
                mem_wdata <= packed_word;
            end else if (done) begin
                mem_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    fmt;
    logic [5:0]    opcode;
    logic [4:0]    rs, rt, rd, shamt;
    logic [5:0]    funct;
    logic [15:0]   imm;
    logic [25:0]   addr;
    logic          mem_we;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   word_count;
    logic          full;
    logic          err;

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fmt        (fmt),
        .opcode     (opcode),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .shamt      (shamt),
        .funct      (funct),
        .imm        (imm),
        .addr       (addr),
        .mem_we     (mem_we),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .word_count (word_count),
        .full       (full),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: "running" flag, words written, optional pending word.
    bit          m_run;
    bit          m_full;
    bit          m_pend;
    bit          m_err;
    logic [31:0] m_dat;
    int          m_count;
    bit          chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_word();
        int unsigned w;
        case (fmt)
            2'd0: w = opcode * 2**26 + rs * 2**21 + rt * 2**16 + rd * 2**11 + shamt * 2**6 + funct;
            2'd1: w = opcode * 2**26 + rs * 2**21 + rt * 2**16 + imm;
            default: w = opcode * 2**26 + addr;
        endcase
        return w;
    endfunction

    function automatic bit model_ok();
        int op;
        op = opcode;
        if (fmt == 2'd3) return 1'b0;
`ifdef ENCODER_FIELD_CHECK_EN
        if (fmt == 2'd0) return op == 0;
        if (fmt == 2'd2) return op == 2 || op == 3;
        return !(op == 0 || op == 2 || op == 3);
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        m_run = 0; m_full = 0; m_pend = 0; m_err = 0; m_dat = 0; m_count = 0;
    endtask

    task automatic model_step();
        bit rdy, last;
        if (reset) begin
            model_reset();
            return;
        end
        if (start) begin
            m_run = 1; m_full = 0; m_pend = 0; m_err = 0; m_count = 0;
            return;
        end
        rdy   = m_run && (!m_pend || mem_ready);
        last  = 0;
        m_err = 0;
        if (m_pend && mem_ready) begin
            m_pend = 0;
            m_count++;
            if (m_count == DEPTH) begin
                last   = 1;
                m_run  = 0;
                m_full = 1;
            end
        end
        if (in_valid && rdy) begin
            if (!model_ok() || last) begin
                m_err = 1;
            end else begin
                m_pend = 1;
                m_dat  = model_word();
            end
        end
    endtask

    // Compare process: DUT outputs against the model every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", {31'd0, in_ready}, {31'd0, m_run && (!m_pend || mem_ready)});
            check("mem_we", {31'd0, mem_we}, {31'd0, m_pend});
            check("full", {31'd0, full}, {31'd0, m_full});
            check("err", {31'd0, err}, {31'd0, m_err});
            check("word_count", 32'(word_count), 32'(m_count));
            check("mem_addr", 32'(mem_addr), 32'(m_count % DEPTH));
            if (m_pend) check("mem_wdata", mem_wdata, m_dat);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_r(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic [4:0] sh, input logic [5:0] fn);
        fmt = 2'd0; opcode = op; rs = s; rt = t; rd = d; shamt = sh; funct = fn;
        imm = $urandom; addr = $urandom;
    endtask

    task automatic set_i(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                         input logic [15:0] im);
        fmt = 2'd1; opcode = op; rs = s; rt = t; imm = im;
        rd = $urandom; shamt = $urandom; funct = $urandom; addr = $urandom;
    endtask

    task automatic set_j(input logic [5:0] op, input logic [25:0] a);
        fmt = 2'd2; opcode = op; addr = a;
        rs = $urandom; rt = $urandom; rd = $urandom; shamt = $urandom;
        funct = $urandom; imm = $urandom;
    endtask

    task automatic do_start();
        start = 1; in_valid = 0; tick(); start = 0;
    endtask

    logic [5:0] rand_op;

    initial begin
        reset = 1; start = 0; in_valid = 0; mem_ready = 1;
        set_r(0, 0, 0, 0, 0, 0);
        model_reset();
        chk_en = 1;
        @(negedge clk);
        check("reset_wdata", mem_wdata, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd0);
        #1;
        tick();
        reset = 0;
        tick();

        // Single R-type word
        do_start();
        set_r(0, 1, 2, 3, 0, 6'h20); in_valid = 1; tick(); in_valid = 0;
        @(negedge clk);
        check("r_we", {31'd0, mem_we}, 32'd1);
        check("r_wdata", mem_wdata, 32'h00221820);
        check("r_addr", 32'(mem_addr), 32'd0);
        #1; tick();
        @(negedge clk);
        check("r_count", 32'(word_count), 32'd1);
        #1;

        // Back-to-back I then J
        do_start();
        set_i(8, 0, 8, 16'd5); in_valid = 1; tick();
        set_j(2, 26'h0100000); tick(); in_valid = 0;
        @(negedge clk);
        check("j_wdata", mem_wdata, 32'h08100000);
        check("j_addr", 32'(mem_addr), 32'd1);
        #1; tick();

        // Stall with a second bundle waiting
        do_start();
        set_r(0, 1, 2, 3, 0, 6'h20); in_valid = 1; tick();
        mem_ready = 0; set_i(8, 0, 8, 16'd5);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("stall_wdata", mem_wdata, 32'h00221820);
            check("stall_addr", 32'(mem_addr), 32'd0);
            check("stall_ready", {31'd0, in_ready}, 32'd0);
            #1;
        end
        mem_ready = 1; tick(); in_valid = 0;
        @(negedge clk);
        check("resume_wdata", mem_wdata, 32'h20080005);
        check("resume_addr", 32'(mem_addr), 32'd1);
        #1; tick();

        // Fill the memory
        do_start();
        in_valid = 1;
        for (int i = 0; i < DEPTH; i++) begin
            set_j(3, 26'(i)); tick();
        end
        in_valid = 0; tick();
        @(negedge clk);
        check("full_flag", {31'd0, full}, 32'd1);
        check("full_addr", 32'(mem_addr), 32'd0);
        check("full_count", 32'(word_count), 32'(DEPTH));
        check("full_ready", {31'd0, in_ready}, 32'd0);
        #1;
        do_start();
        @(negedge clk);
        check("reopen_count", 32'(word_count), 32'd0);
        check("reopen_full", {31'd0, full}, 32'd0);
        #1;

        // Reserved format
        fmt = 2'd3; in_valid = 1; tick(); in_valid = 0;
        @(negedge clk);
        check("rsv_err", {31'd0, err}, 32'd1);
        check("rsv_we", {31'd0, mem_we}, 32'd0);
        check("rsv_addr", 32'(mem_addr), 32'd0);
        #1; tick();
        @(negedge clk);
        check("rsv_err_clear", {31'd0, err}, 32'd0);
        #1;

        // R-type with a non-zero opcode
        set_r(8, 1, 2, 3, 0, 6'h20); in_valid = 1; tick(); in_valid = 0;
        @(negedge clk);
`ifdef ENCODER_FIELD_CHECK_EN
        check("op8_err", {31'd0, err}, 32'd1);
        check("op8_we", {31'd0, mem_we}, 32'd0);
`else
        check("op8_wdata", mem_wdata, 32'h20221820);
        check("op8_err", {31'd0, err}, 32'd0);
`endif
        #1; tick();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            start     = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            mem_ready = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 4))
                0: rand_op = 6'd0;
                1: rand_op = 6'd2;
                2: rand_op = 6'd3;
                default: rand_op = 6'($urandom);
            endcase
            fmt = 2'($urandom); opcode = rand_op;
            rs = $urandom; rt = $urandom; rd = $urandom; shamt = $urandom;
            funct = $urandom; imm = $urandom; addr = $urandom;
            tick();
        end

        // Asynchronous reset in the middle of traffic
        do_start();
        set_r(0, 4, 5, 6, 0, 6'h21); in_valid = 1; mem_ready = 0; tick();
        in_valid = 0;
        reset = 1; model_reset(); #1;
        check("async_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        check("arst_count", 32'(word_count), 32'd0);
        #1;
        reset = 0; mem_ready = 1;
        tick(); tick();

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
